// File: rtl/arbitro_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_pkg
// Shared definitions for the operation-unit arbiter:
//   estado_t : arbiter state (INACTIVO, EJECUTA, FIN)
//   NUM_REQ  : number of requesters sharing the operation unit
//   OP_W     : width of one operation code
//   CNT_W    : width of the latency counter
//   IDX_W    : width of a requester index
//   one_hot  : requester index -> one-hot requester vector
// -----------------------------------------------------------------------------
package arbitro_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned OP_W    = 2;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned IDX_W   = 2;

   typedef enum logic [1:0] {
      INACTIVO,
      EJECUTA,
      FIN
   } estado_t;

   function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/selector_rr.sv
// -----------------------------------------------------------------------------
// selector_rr
// Combinational round-robin pick: first request bit that is set and not masked,
// searching upward from the pointer and wrapping 3 -> 0.
//   req   in  NUM_REQ  request vector
//   mask  in  NUM_REQ  bits to exclude from the search
//   ptr   in  IDX_W    index the search starts at
//   valid out 1        at least one eligible request
//   idx   out IDX_W    winning index (0 when valid is low)
// -----------------------------------------------------------------------------
module selector_rr
   import arbitro_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   logic [NUM_REQ-1:0] eleg;
   logic [IDX_W-1:0]   cand;

   assign eleg = req & ~mask;

   // Walk offsets from farthest to nearest so the candidate closest to the
   // pointer is the last one written and therefore wins. The candidate index
   // wraps naturally because it is IDX_W bits wide.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned k = NUM_REQ; k > 0; k--) begin
         cand = ptr + IDX_W'(k - 1);
         if (eleg[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/arbitro_operaciones.sv
// -----------------------------------------------------------------------------
// arbitro_operaciones
// Round-robin arbiter/sequencer sharing one four-operation unit among four
// requesters. One grant at a time, held for LAT cycles with the decoder
// enabled, followed by a one-cycle completion pulse to the served requester.
//   LAT      param     cycles per operation (1..15)
//   clk      in  1     clock, rising edge
//   rst      in  1     synchronous active-high reset
//   req      in  4     level request per requester
//   op_req   in  8     op code of requester i on bits [2i+1:2i]
//   in_op    out 2     op code to the 2-to-4 decoder
//   en       out 1     decoder enable
//   gnt      out 4     one-hot grant, held for the whole operation
//   listo    out 4     one-hot completion pulse
//   ocupado  out 1     high whenever the arbiter is not idle
// All outputs are flops loaded from next-state values, so they line up with
// the state register and have no combinational path from the inputs.
// -----------------------------------------------------------------------------
module arbitro_operaciones
   import arbitro_pkg::*;
#(
   parameter int unsigned LAT = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*OP_W-1:0] op_req,
   output logic [OP_W-1:0]         in_op,
   output logic                    en,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      listo,
   output logic                    ocupado
);

   localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(LAT - 1);

   estado_t            estado, estado_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [IDX_W-1:0]   ptr, ptr_n;
   logic [IDX_W-1:0]   idx_q, idx_n;
   logic [OP_W-1:0]    op_q, op_n;
   logic               post_fin;

   logic [NUM_REQ-1:0] mask;
   logic               sel_valid;
   logic [IDX_W-1:0]   sel_idx;
   logic [OP_W-1:0]    op_arr [NUM_REQ];

   logic [OP_W-1:0]    in_op_n;
   logic               en_n;
   logic [NUM_REQ-1:0] gnt_n;
   logic [NUM_REQ-1:0] listo_n;
   logic               ocupado_n;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_op
      assign op_arr[i] = op_req[OP_W*i +: OP_W];
   end

   // In the idle cycle right after FIN the just-served requester has only
   // just seen listo and may still be holding req; keep it out of that pick.
   assign mask = post_fin ? one_hot(idx_q) : '0;

   selector_rr u_selector_rr (
      .req   (req),
      .mask  (mask),
      .ptr   (ptr),
      .valid (sel_valid),
      .idx   (sel_idx)
   );

   always_comb begin
      estado_n = estado;
      cnt_n    = cnt;
      ptr_n    = ptr;
      idx_n    = idx_q;
      op_n     = op_q;

      unique case (estado)
         INACTIVO: begin
            if (sel_valid) begin
               idx_n    = sel_idx;
               op_n     = op_arr[sel_idx];
               cnt_n    = CNT_INI;
               estado_n = EJECUTA;
            end
         end
         EJECUTA: begin
            if (cnt == '0) begin
               estado_n = FIN;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         FIN: begin
            ptr_n    = idx_q + IDX_W'(1);
            estado_n = INACTIVO;
         end
         default: begin
            estado_n = INACTIVO;
         end
      endcase

      en_n      = (estado_n == EJECUTA);
      gnt_n     = en_n ? one_hot(idx_n) : '0;
      in_op_n   = en_n ? op_n : '0;
      listo_n   = (estado_n == FIN) ? one_hot(idx_n) : '0;
      ocupado_n = (estado_n != INACTIVO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado   <= INACTIVO;
         cnt      <= '0;
         ptr      <= '0;
         idx_q    <= '0;
         op_q     <= '0;
         post_fin <= 1'b0;
         in_op    <= '0;
         en       <= 1'b0;
         gnt      <= '0;
         listo    <= '0;
         ocupado  <= 1'b0;
      end else begin
         estado   <= estado_n;
         cnt      <= cnt_n;
         ptr      <= ptr_n;
         idx_q    <= idx_n;
         op_q     <= op_n;
         post_fin <= (estado == FIN);
         in_op    <= in_op_n;
         en       <= en_n;
         gnt      <= gnt_n;
         listo    <= listo_n;
         ocupado  <= ocupado_n;
      end
   end

endmodule

// File: doc/arbitro_operaciones.md
# arbitro_operaciones

Round-robin arbiter and sequencer that shares the single four-operation unit among four requesters. It grants one requester at a time and drives the 2-bit operation code and enable into the 2-to-4 operation decoder. It holds that grant for a fixed operation latency, then returns a one-cycle completion pulse to the served requester.

## Interface
- LAT, default 3, cycles the operation unit needs per operation; legal range 1..15
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  level request, one bit per requester
- op_req  in  8  requested op code; requester i on bits [2i+1:2i]
- in_op  out  2  op code to the decoder
- en  out  1  decoder enable
- gnt  out  4  one-hot grant, held for the whole operation
- listo  out  4  one-hot completion pulse, one cycle
- ocupado  out  1  high whenever state is not INACTIVO

## Operation
- States:
  - INACTIVO: no grant.
  - EJECUTA: operation running, counter active.
  - FIN: completion.
- Reset (synchronous, any state): next state INACTIVO; pointer = 0; counter = 0; in_op = 2'b00; en, gnt, listo, ocupado = 0; captured index/op cleared. Reset mid-operation aborts it and produces no listo.
- INACTIVO: if any eligible req bit is set, pick the first set bit searching upward from pointer with wrap (3 -> 0). Register the index and its op_req field, load counter = LAT-1, go to EJECUTA. With no eligible request, stay.
- Eligibility: all req bits, except in the single INACTIVO cycle immediately after FIN. In that cycle the just-served index is masked, so a requester still holding req cannot be re-granted before it has seen listo.
- EJECUTA: en = 1, in_op = captured op, gnt = one-hot(captured index).
  - Counter decrements each cycle; at 0 go to FIN.
  - Changes on req/op_req of the granted requester are ignored; the operation always completes.
- FIN:
  - en = 0, gnt = 0, listo = one-hot(captured index) for exactly this cycle.
  - pointer <= captured index + 1 (mod 4), then go to INACTIVO.
- All outputs are registered; no combinational path from req/op_req to any output.
- Requester contract: hold req until listo is seen, then drop it. A req still high in the second cycle after listo counts as a new request.

## Timing
- req sampled at edge N (state INACTIVO): edge N+1 gives en = 1, gnt/in_op valid.
- en is high for exactly LAT cycles.
- Edge N+1+LAT gives FIN (listo high one cycle).
- Edge N+2+LAT returns to INACTIVO.
- Back-to-back throughput is one operation per LAT+2 cycles.
- LAT = 1: EJECUTA lasts one cycle, counter loaded with 0.
- Simultaneous requests: exactly one grant, chosen by the pointer. Under full load, service order rotates 0,1,2,3,0…
- en and listo are never high in the same cycle. gnt and listo are never both non-zero.

## Structure
- Shared package `arbitro_pkg`:
  - state enum (INACTIVO, EJECUTA, FIN)
  - NUM_REQ = 4
  - OP_W = 2
  - counter width CNT_W = 4
- Sub-module `selector_rr`: purely combinational. Inputs are the 4-bit request vector, 4-bit mask and 2-bit pointer. Outputs are a valid bit and the 2-bit winning index.
- Top: FSM, counter, pointer and capture registers, output registers.

## Test plan
- Reset: hold rst 2 cycles mid-EJECUTA with LAT=3 -> next edge all outputs 0, state INACTIVO, no listo ever issued for the aborted operation.
- Single request: req=0100, op_req[5:4]=10, LAT=3 sampled at edge 0.
  - edges 1–3: en=1, in_op=10, gnt=0100.
  - edge 4: listo=0100, en=0.
  - edge 5: ocupado=0.
- Full load: req=1111 held, ops 00/01/10/11, pointer 0 -> grants 0001,0010,0100,1000,0001 at 5-cycle spacing; in_op follows 00,01,10,11.
- Held request after listo: only req[1] set and kept high -> masked for one INACTIVO cycle, then re-granted; a second listo is issued LAT+3 cycles after the first.
- Op change mid-operation: change op_req during EJECUTA -> in_op unchanged until FIN. Drop req during EJECUTA -> operation still completes with listo.
- LAT=1: en high exactly one cycle per grant; listo on the following edge.
